// File: rtl/irq_pkg.sv
// irq_pkg: register indices, FSM encoding and reset constants shared by the interrupt scheduler.
package irq_pkg;
  localparam logic [4:0] IRQ_REG_COUNT   = 5'd0;
  localparam logic [4:0] IRQ_REG_COMPARE = 5'd1;
  localparam logic [4:0] IRQ_REG_PENDING = 5'd2;
  localparam logic [4:0] IRQ_REG_MASK    = 5'd3;
  localparam logic [4:0] IRQ_REG_ACTIVE  = 5'd4;
  localparam logic [31:0] IRQ_COMPARE_RST = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SERVICE = 2'd2} irq_state_e;
endpackage

// File: rtl/irq_arbiter.sv
// irq_arbiter: picks one eligible source; fixed lowest-index priority, or round-robin from ptr_i
// when IRQ_ROUND_ROBIN_EN is defined.
module irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic [NUM_SRC-1:0] elig_i,
`ifdef IRQ_ROUND_ROBIN_EN
  input  logic [ID_W-1:0]    ptr_i,
`endif
  output logic [ID_W-1:0]    win_id_o,
  output logic               win_valid_o
);
`ifdef IRQ_ROUND_ROBIN_EN
  int idx;
  always_comb begin
    win_id_o    = '0;
    win_valid_o = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr_i) + k) % NUM_SRC;
      if (!win_valid_o && elig_i[idx]) begin
        win_id_o    = ID_W'(idx);
        win_valid_o = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_id_o    = '0;
    win_valid_o = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig_i[i]) begin
        win_id_o    = ID_W'(i);
        win_valid_o = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/irq_scheduler.sv
// irq_scheduler: masks timer + device requests and raises one interrupt to cp0, tracking service state.
// Optional IRQ_ROUND_ROBIN_EN switches the arbiter to round-robin with a rotating pointer.
module irq_scheduler
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [4:0]         regnum_i,
  input  logic [31:0]        wr_data_i,
  output logic [31:0]        rd_data_o,
  input  logic [NUM_SRC-1:0] src_req_i,
  input  logic               taken_i,
  input  logic               eret_i,
  output logic               irq_out_o,
  output logic [ID_W-1:0]    active_id_o
);
  logic [31:0]        count_q, count_d, compare_q, compare_d;
  logic [NUM_SRC-1:0] pend_q, pend_d, mask_q, mask_d, elig, set, w1c, take_clr;
  logic [ID_W-1:0]    win_id, active_id_q;
  logic               win_valid, wr_cnt, wr_cmp, take;
  irq_state_e         state_q;

  assign wr_cnt   = wr_en_i && regnum_i == IRQ_REG_COUNT;
  assign wr_cmp   = wr_en_i && regnum_i == IRQ_REG_COMPARE;
  assign take     = state_q == ARMED && taken_i;
  assign elig     = pend_q & mask_q;
  assign set      = {src_req_i[NUM_SRC-1:1], count_q == compare_q};
  assign w1c      = (wr_en_i && regnum_i == IRQ_REG_PENDING) ? wr_data_i[NUM_SRC-1:0] : '0;
  assign take_clr = (take && win_valid) ? {{(NUM_SRC-1){1'b0}}, 1'b1} << win_id : '0;
  // Grant clear beats a same-cycle request; a COMPARE write beats a same-cycle timer match.
  assign pend_d    = (((pend_q & ~w1c) | set) & ~take_clr) & ~{{(NUM_SRC-1){1'b0}}, wr_cmp};
  assign count_d   = wr_cnt ? wr_data_i : count_q + 32'd1;
  assign compare_d = wr_cmp ? wr_data_i : compare_q;
  assign mask_d    = (wr_en_i && regnum_i == IRQ_REG_MASK) ? wr_data_i[NUM_SRC-1:0] : mask_q;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else if (take) ptr_q <= (win_id == ID_W'(NUM_SRC - 1)) ? '0 : win_id + 1'b1;
  end
`endif

  irq_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_arb (
    .elig_i      (elig),
`ifdef IRQ_ROUND_ROBIN_EN
    .ptr_i       (ptr_q),
`endif
    .win_id_o    (win_id),
    .win_valid_o (win_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      compare_q <= IRQ_COMPARE_RST;
      pend_q    <= '0;
      mask_q    <= '0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      active_id_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (win_valid) state_q <= ARMED;
        ARMED:   if (taken_i) begin
                   state_q     <= SERVICE;
                   active_id_q <= win_id;
                 end else if (!win_valid) state_q <= IDLE;
        SERVICE: if (eret_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_out_o   = state_q == ARMED;
  assign active_id_o = active_id_q;
  assign rd_data_o   = (regnum_i == IRQ_REG_COUNT)   ? count_q :
                       (regnum_i == IRQ_REG_COMPARE) ? compare_q :
                       (regnum_i == IRQ_REG_PENDING) ? 32'(pend_q) :
                       (regnum_i == IRQ_REG_MASK)    ? 32'(mask_q) :
                       (regnum_i == IRQ_REG_ACTIVE)  ? 32'(active_id_q) : 32'd0;
endmodule

// File: tb/tb_irq_scheduler.sv
// tb_irq_scheduler: directed checks of timer, priority, masking, collisions, wrap and async reset.
module tb_irq_scheduler;
  import irq_pkg::*;
  logic        clk_i = 1'b0, rst_ni = 1'b0, wr_en_i = 1'b0, taken_i = 1'b0, eret_i = 1'b0;
  logic [4:0]  regnum_i = '0;
  logic [31:0] wr_data_i = '0, rd_data_o;
  logic [7:0]  src_req_i = '0;
  logic        irq_out_o;
  logic [4:0]  active_id_o;
  int          n_chk = 0, n_pass = 0;
`ifdef IRQ_ROUND_ROBIN_EN
  localparam logic [31:0] RR_FIRST = 32'd5, RR_SECOND = 32'd2;
`else
  localparam logic [31:0] RR_FIRST = 32'd2, RR_SECOND = 32'd5;
`endif

  irq_scheduler #(.NUM_SRC(8), .ID_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .regnum_i(regnum_i),
    .wr_data_i(wr_data_i), .rd_data_o(rd_data_o), .src_req_i(src_req_i),
    .taken_i(taken_i), .eret_i(eret_i), .irq_out_o(irq_out_o), .active_id_o(active_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    wr_en_i = 1'b1; regnum_i = r; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    regnum_i = r;
    #1;
    chk(tag, rd_data_o, exp);
  endtask

  task automatic pulse_req(input logic [7:0] v);
    src_req_i = v;
    tick();
    src_req_i = '0;
  endtask

  task automatic grant(input string tag, input logic [31:0] exp_id);
    taken_i = 1'b1;
    tick();
    taken_i = 1'b0;
    chk({tag, "_id"}, 32'(active_id_o), exp_id);
    chk({tag, "_irq"}, 32'(irq_out_o), 32'd0);
  endtask

  task automatic finish_service();
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst_ni = 1'b1;
    chk("rst_irq", 32'(irq_out_o), 32'd0);
    chk("rst_active", 32'(active_id_o), 32'd0);
    chk_reg("rst_compare", IRQ_REG_COMPARE, 32'hFFFF_FFFF);
    chk_reg("rst_pending", IRQ_REG_PENDING, 32'd0);
    chk_reg("rst_mask", IRQ_REG_MASK, 32'd0);
    chk_reg("unused_reg", 5'd7, 32'd0);
    // timer: match at COUNT==10, pending one cycle later, irq one more
    wr(IRQ_REG_MASK, 32'd1);
    wr(IRQ_REG_COMPARE, 32'd10);
    wr(IRQ_REG_COUNT, 32'd0);
    repeat (10) tick();
    chk_reg("tmr_count", IRQ_REG_COUNT, 32'd10);
    chk_reg("tmr_pend_pre", IRQ_REG_PENDING, 32'd0);
    tick();
    chk_reg("tmr_pend", IRQ_REG_PENDING, 32'd1);
    chk("tmr_irq_lat", 32'(irq_out_o), 32'd0);
    tick();
    chk("tmr_irq", 32'(irq_out_o), 32'd1);
    grant("tmr_grant", 32'd0);
    chk_reg("tmr_pend_clr", IRQ_REG_PENDING, 32'd0);
    chk_reg("tmr_active_reg", IRQ_REG_ACTIVE, 32'd0);
    finish_service();
    tick();
    chk("tmr_idle", 32'(irq_out_o), 32'd0);
    // priority: ids 2 and 5 both pending
    wr(IRQ_REG_MASK, 32'hFF);
    pulse_req(8'b0010_0100);
    chk_reg("pri_pend", IRQ_REG_PENDING, 32'h24);
    tick();
    chk("pri_irq", 32'(irq_out_o), 32'd1);
    grant("pri_g1", 32'd2);
    chk_reg("pri_pend2", IRQ_REG_PENDING, 32'h20);
    finish_service();
    chk("pri_eret1", 32'(irq_out_o), 32'd0);
    tick();
    chk("pri_eret2", 32'(irq_out_o), 32'd1);
    grant("pri_g2", 32'd5);
    finish_service();
    // round-robin distinguishing case: grant 2 alone, then 2 and 5 together
    pulse_req(8'b0000_0100);
    tick();
    grant("rr_g0", 32'd2);
    finish_service();
    pulse_req(8'b0010_0100);
    tick();
    grant("rr_g1", RR_FIRST);
    finish_service();
    tick();
    grant("rr_g2", RR_SECOND);
    finish_service();
    // masking and withdraw
    wr(IRQ_REG_MASK, 32'd0);
    pulse_req(8'b0000_1000);
    tick(); tick();
    chk("msk_irq", 32'(irq_out_o), 32'd0);
    chk_reg("msk_pend", IRQ_REG_PENDING, 32'h08);
    wr(IRQ_REG_MASK, 32'h08);
    tick();
    chk("msk_armed", 32'(irq_out_o), 32'd1);
    wr(IRQ_REG_PENDING, 32'h08);
    chk("wd_still", 32'(irq_out_o), 32'd1);
    tick();
    chk("wd_fall", 32'(irq_out_o), 32'd0);
    // collisions
    wr(IRQ_REG_MASK, 32'd0);
    src_req_i = 8'h10;
    tick();
    wr(IRQ_REG_PENDING, 32'h10);
    chk_reg("w1c_setwins", IRQ_REG_PENDING, 32'h10);
    src_req_i = '0;
    wr(IRQ_REG_PENDING, 32'h10);
    chk_reg("w1c_clr", IRQ_REG_PENDING, 32'h00);
    wr(IRQ_REG_COMPARE, 32'd102);
    wr(IRQ_REG_COUNT, 32'd100);
    tick(); tick();
    chk_reg("cmp_match_cnt", IRQ_REG_COUNT, 32'd102);
    wr(IRQ_REG_COMPARE, 32'd102);
    chk_reg("cmp_wr_beats", IRQ_REG_PENDING, 32'd0);
    wr(IRQ_REG_MASK, 32'hFF);
    pulse_req(8'b0000_0010);
    tick();
    chk("te_armed", 32'(irq_out_o), 32'd1);
    taken_i = 1'b1; eret_i = 1'b1;
    tick();
    taken_i = 1'b0; eret_i = 1'b0;
    chk("te_id", 32'(active_id_o), 32'd1);
    pulse_req(8'b0000_0001);
    chk_reg("te_src0_ignored", IRQ_REG_PENDING, 32'd0);
    pulse_req(8'b0100_0000);
    tick();
    chk("te_service_holds", 32'(irq_out_o), 32'd0);
    finish_service();
    tick();
    chk("te_rearm", 32'(irq_out_o), 32'd1);
    grant("te_g", 32'd6);
    finish_service();
    // wrap
    wr(IRQ_REG_MASK, 32'd1);
    wr(IRQ_REG_COMPARE, 32'd0);
    wr(IRQ_REG_COUNT, 32'hFFFF_FFFE);
    tick();
    chk_reg("wrap_ff", IRQ_REG_COUNT, 32'hFFFF_FFFF);
    tick();
    chk_reg("wrap_0", IRQ_REG_COUNT, 32'd0);
    tick();
    chk_reg("wrap_pend", IRQ_REG_PENDING, 32'd1);
    // async reset in SERVICE
    tick();
    grant("ar_g", 32'd0);
    wr(IRQ_REG_MASK, 32'h08);
    pulse_req(8'b0000_1000);
    chk_reg("ar_pend_pre", IRQ_REG_PENDING, 32'h08);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("ar_irq", 32'(irq_out_o), 32'd0);
    chk_reg("ar_pend", IRQ_REG_PENDING, 32'd0);
    chk_reg("ar_count", IRQ_REG_COUNT, 32'd0);
    chk_reg("ar_mask", IRQ_REG_MASK, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("ar_idle", 32'(irq_out_o), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
